// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous
// write port, debug read port and a committed-write counter. $0 reads as zero.
module mips_regfile #(
    parameter bit          WRITE_THROUGH = 1'b0,
    parameter logic [31:0] GP_INIT       = 32'h0000_1800,
    parameter logic [31:0] SP_INIT       = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] wr_count
);

    localparam int unsigned DW      = 32;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned GP_IDX  = 28;
    localparam int unsigned SP_IDX  = 29;

    logic [DW-1:0] regs [NREGS];
    logic          wr_commit;

    // A write commits only when not in reset and not aimed at $0
    assign wr_commit = we3 && (a3 != 5'd0) && !reset;

    // Storage and write counter; reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            regs[GP_IDX] <= GP_INIT;
            regs[SP_IDX] <= SP_INIT;
            wr_count     <= '0;
        end else if (wr_commit) begin
            regs[a3]     <= wd3;
            wr_count     <= wr_count + DW'(1);
        end
    end

    // Read ports: $0 forced to zero, optional same-cycle bypass of the write data
    always_comb begin
        rd1 = (a1 == 5'd0) ? '0 : regs[a1];
        rd2 = (a2 == 5'd0) ? '0 : regs[a2];
        if (WRITE_THROUGH && we3 && (a3 != 5'd0)) begin
            if (a3 == a1) rd1 = wd3;
            if (a3 == a2) rd2 = wd3;
        end
    end

    // Debug port always shows committed storage
    always_comb begin
        dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: two instances (no bypass / bypass) share stimulus and
// are compared against an array-based reference model.
module tb_mips_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  a1, a2, a3, dbg_addr;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1_0, rd2_0, dbg_0, cnt_0;
    logic [31:0] rd1_1, rd2_1, dbg_1, cnt_1;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];
    logic [31:0] model_cnt;

    mips_regfile #(.WRITE_THROUGH(1'b0)) dut0 (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
        .rd1(rd1_0), .rd2(rd2_0), .dbg_addr(dbg_addr), .dbg_data(dbg_0), .wr_count(cnt_0)
    );

    mips_regfile #(.WRITE_THROUGH(1'b1)) dut1 (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
        .rd1(rd1_1), .rd2(rd2_1), .dbg_addr(dbg_addr), .dbg_data(dbg_1), .wr_count(cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for a port, with or without same-cycle bypass
    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit wt);
        if (wt && we3 && a3 != 5'd0 && a3 == addr) return wd3;
        return model[addr];
    endfunction

    // Advance the model by the rules for one rising edge, then clock the DUTs
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[28] = 32'h0000_1800;
            model[29] = 32'h0000_3FFC;
            model_cnt = 32'h0;
        end else if (we3 && a3 != 5'd0) begin
            model[a3] = wd3;
            model_cnt = model_cnt + 32'h1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        we3 = 1'b1; a3 = addr; wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; we3 = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e;
            e = (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_3FFC : 32'h0;
            a1 = 5'(i); a2 = 5'(31 - i); dbg_addr = 5'(i);
            @(negedge clk);
            total++; if (rd1_0 !== e) begin bad++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", i, rd1_0, e); end
            total++; if (dbg_1 !== e) begin bad++; $display("FAIL reset_dbg a=%0d got=%h exp=%h", i, dbg_1, e); end
            total++; if (rd2_1 !== model[31 - i]) begin bad++; $display("FAIL reset_rd2 a=%0d got=%h exp=%h", 31 - i, rd2_1, model[31 - i]); end
        end
        total++; if (cnt_0 !== 32'h0 || cnt_1 !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0", cnt_0, cnt_1); end
    endtask

    task automatic test_basic_write();
        write_reg(5'd5, 32'hDEAD_BEEF);
        a1 = 5'd5; a2 = 5'd5;
        @(negedge clk);
        total++; if (rd1_0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rd1 got=%h exp=deadbeef", rd1_0); end
        total++; if (rd2_0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rd2 got=%h exp=deadbeef", rd2_0); end
        total++; if (cnt_0 !== 32'h1) begin bad++; $display("FAIL basic_cnt got=%h exp=1", cnt_0); end
    endtask

    task automatic test_zero_write();
        a1 = 5'd0; a2 = 5'd0; dbg_addr = 5'd0;
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (rd1_1 !== 32'h0) begin bad++; $display("FAIL zero_bypass_rd1 got=%h exp=0", rd1_1); end
        tick();
        we3 = 1'b0;
        @(negedge clk);
        total++; if (rd1_0 !== 32'h0 || rd2_1 !== 32'h0) begin bad++; $display("FAIL zero_rd got=%h/%h exp=0", rd1_0, rd2_1); end
        total++; if (dbg_0 !== 32'h0) begin bad++; $display("FAIL zero_dbg got=%h exp=0", dbg_0); end
        total++; if (cnt_0 !== model_cnt) begin bad++; $display("FAIL zero_cnt got=%h exp=%h", cnt_0, model_cnt); end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd7, 32'h11);
        a1 = 5'd7; a2 = 5'd3; dbg_addr = 5'd7;
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h22;
        @(negedge clk);
        total++; if (rd1_0 !== 32'h11) begin bad++; $display("FAIL rdw_nowt_before got=%h exp=11", rd1_0); end
        total++; if (rd1_1 !== 32'h22) begin bad++; $display("FAIL rdw_wt_before got=%h exp=22", rd1_1); end
        total++; if (dbg_1 !== 32'h11) begin bad++; $display("FAIL rdw_wt_dbg got=%h exp=11", dbg_1); end
        tick();
        we3 = 1'b0;
        @(negedge clk);
        total++; if (rd1_0 !== 32'h22) begin bad++; $display("FAIL rdw_nowt_after got=%h exp=22", rd1_0); end
        total++; if (rd1_1 !== 32'h22) begin bad++; $display("FAIL rdw_wt_after got=%h exp=22", rd1_1); end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd9, 32'h77);
        reset = 1'b1; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h55;
        tick();
        reset = 1'b0; we3 = 1'b0;
        a1 = 5'd9; a2 = 5'd5; dbg_addr = 5'd9;
        @(negedge clk);
        total++; if (rd1_0 !== 32'h0) begin bad++; $display("FAIL rstpri_r9 got=%h exp=0", rd1_0); end
        total++; if (rd2_0 !== 32'h0) begin bad++; $display("FAIL rstpri_r5 got=%h exp=0", rd2_0); end
        total++; if (cnt_0 !== 32'h0 || cnt_1 !== 32'h0) begin bad++; $display("FAIL rstpri_cnt got=%h/%h exp=0", cnt_0, cnt_1); end
    endtask

    task automatic test_fill_all();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e;
            logic [31:0] e2;
            e  = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            e2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
            a1 = 5'(i); a2 = 5'(31 - i); dbg_addr = 5'(i);
            @(negedge clk);
            total++; if (rd1_0 !== e || rd1_1 !== e) begin bad++; $display("FAIL fill_rd1 a=%0d got=%h/%h exp=%h", i, rd1_0, rd1_1, e); end
            total++; if (rd2_0 !== e2 || rd2_1 !== e2) begin bad++; $display("FAIL fill_rd2 a=%0d got=%h/%h exp=%h", 31 - i, rd2_0, rd2_1, e2); end
            total++; if (dbg_0 !== e) begin bad++; $display("FAIL fill_dbg a=%0d got=%h exp=%h", i, dbg_0, e); end
        end
        total++; if (cnt_0 !== 32'd31 || cnt_1 !== 32'd31) begin bad++; $display("FAIL fill_cnt got=%0d/%0d exp=31", cnt_0, cnt_1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] e1_0, e2_0, e1_1, e2_1;
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            a3 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            we3 = 1'($urandom_range(0, 1));
            wd3 = $urandom;
            dbg_addr = ($urandom_range(0, 1) == 0) ? a3 : 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 40) == 0);
            e1_0 = exp_rd(a1, 1'b0); e2_0 = exp_rd(a2, 1'b0);
            e1_1 = exp_rd(a1, 1'b1); e2_1 = exp_rd(a2, 1'b1);
            @(negedge clk);
            total++; if (rd1_0 !== e1_0 || rd2_0 !== e2_0) begin bad++; $display("FAIL rand_nowt n=%0d got=%h/%h exp=%h/%h", n, rd1_0, rd2_0, e1_0, e2_0); end
            total++; if (rd1_1 !== e1_1 || rd2_1 !== e2_1) begin bad++; $display("FAIL rand_wt n=%0d got=%h/%h exp=%h/%h", n, rd1_1, rd2_1, e1_1, e2_1); end
            total++; if (dbg_0 !== model[dbg_addr] || dbg_1 !== model[dbg_addr]) begin bad++; $display("FAIL rand_dbg n=%0d got=%h/%h exp=%h", n, dbg_0, dbg_1, model[dbg_addr]); end
            total++; if (cnt_0 !== model_cnt || cnt_1 !== model_cnt) begin bad++; $display("FAIL rand_cnt n=%0d got=%h/%h exp=%h", n, cnt_0, cnt_1, model_cnt); end
            tick();
        end
        reset = 1'b0; we3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; dbg_addr = '0;
        model_cnt = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_basic_write();
        test_zero_write();
        test_read_during_write();
        test_reset_priority();
        test_fill_all();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit general-purpose register file for the MIPS32 single-cycle datapath; sits directly upstream of the ALU.
- Two combinational read ports drive the ALU operands: rd1 feeds srcA; rd2 feeds srcB via the immediate mux.
- One synchronous write port takes the writeback value (ALU result or memory data) at the end of the instruction cycle.
- Register $0 is hard-wired to zero. $gp and $sp take configurable values at reset.

Parameters:
- WRITE_THROUGH, 0, 1 = a same-cycle write to a read address is bypassed to that read port. Keep 0 in the single-cycle core, because wd3 depends combinationally on rd1/rd2.
- GP_INIT, 32'h00001800, value loaded into $28 ($gp) on reset.
- SP_INIT, 32'h00003FFC, value loaded into $29 ($sp) on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a1  input  5  read address, port 1 (instr[25:21], rs).
- a2  input  5  read address, port 2 (instr[20:16], rt).
- a3  input  5  write address (rt or rd, selected by regdst).
- we3  input  1  write enable (regwrite).
- wd3  input  32  write data (result bus).
- rd1  output  32  read data, port 1; drives ALU srcA.
- rd2  output  32  read data, port 2; drives ALU srcB mux.
- dbg_addr  input  5  debug/testbench read address.
- dbg_data  output  32  debug read data; combinational; never bypassed.
- wr_count  output  32  count of committed register writes; wraps modulo 2^32.

Behaviour:
- Storage: 32 entries x 32 bits. Entry 0 is not writable and always reads 32'h0 on every port.
- Reset: the only reset is synchronous, active-high `reset` on clk.
  - When reset is sampled high at a rising edge: all entries become 0, except $28 = GP_INIT and $29 = SP_INIT; wr_count becomes 0.
  - Reset has priority over a simultaneous write; the write is dropped and not counted.
  - Reset asserted between writes discards all prior contents at that edge.
- Reset values seen at the outputs (outputs are combinational from storage, so these follow the first edge with reset high):
  - rd1, rd2, dbg_data read 0 for every address except 28 (GP_INIT) and 29 (SP_INIT).
  - wr_count = 0.
  - Before the first reset edge, contents are undefined.
- Read: rd1 = R[a1], rd2 = R[a2], dbg_data = R[dbg_addr]. Purely combinational, zero latency. Reading address 0 returns 0.
- Write: at a rising edge with reset=0, we3=1 and a3!=0, R[a3] <= wd3 and wr_count <= wr_count+1.
  - we3=1 with a3=0 is a legal no-op: no storage change, wr_count unchanged.
  - we3=0: no change.
- Read-during-write, same address, WRITE_THROUGH=0: the read port shows the old value until the edge, then the new value.
- Read-during-write, WRITE_THROUGH=1: if we3=1, a3!=0 and a3==a1 (or a2), that port shows wd3 in the same cycle. Never bypassed for a3=0. dbg_data is never bypassed.
- a1==a2: both ports return the same value; no interaction.
- Back-to-back writes to the same register: the last edge wins; each write counts.
- wr_count wraps from 32'hFFFFFFFF to 0.
- All inputs are assumed 2-state. The X on storage before the first reset is not masked.

Test Plan:
- Reset pulse for 1 cycle, then sweep a1 over 0..31 -> rd1 = 0 everywhere except a1=28 -> 32'h00001800 and a1=29 -> 32'h00003FFC; wr_count = 0.
- we3=1, a3=5, wd3=32'hDEADBEEF for one edge; then a1=5, a2=5 -> rd1 = rd2 = 32'hDEADBEEF; wr_count = 1.
- we3=1, a3=0, wd3=32'hFFFFFFFF -> rd1 at a1=0 stays 0; wr_count unchanged.
- WRITE_THROUGH=0: a1=7 holding 32'h11, we3=1, a3=7, wd3=32'h22 -> rd1=32'h11 before the edge, 32'h22 after.
  - Repeat with WRITE_THROUGH=1 -> rd1=32'h22 before the edge; dbg_data at 7 = 32'h11 before the edge.
- Reset and we3=1 (a3=9, wd3=32'h55) in the same cycle -> R[9]=0 afterwards; wr_count=0.
- Write all 31 registers with value = 32'h100+index, then read via both ports and dbg_addr -> every port returns the matching value; wr_count=31.
